// File: rtl/haski_pkg.sv
// Shared definitions for the HaSKI core-output receiver: core word layout and
// receiver state encoding.
package haski_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned RES_VALID_BIT = DEF_DATA_W + 1;
  localparam int unsigned HALT_BIT      = 0;
  localparam int unsigned RES_LSB       = 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/haski_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The head word is presented
// combinationally and reads as zero while the FIFO is empty.
module haski_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the data array is deliberately not reset; the pointers alone decide
  // which entries are valid, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/haski_result_receiver.sv
// Receives the HaSKI core output word, queues valid results and streams them
// downstream; tracks halt/drain, delivered-result count and dropped results.
module haski_result_receiver
  import haski_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic [DATA_W+1:0] core_i,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              halted,
  output logic              overflow,
  output logic [CNT_W-1:0]  res_count
);

  localparam int VALID_BIT = DATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W+1:0] in_q;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              push;
  logic              pop;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) in_q <= '0;
    else                in_q <= core_i;
  end

  // A push while full is only accepted if the head leaves in the same cycle.
  assign push_req  = in_q[VALID_BIT] && (state == RUN);
  assign pop       = res_valid && res_ready;
  assign push      = push_req && (!full || pop);
  assign res_valid = !empty;
  assign halted    = (state == HALTED);

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (in_q[HALT_BIT]) state_nxt = DRAIN;
      DRAIN:   if (empty)          state_nxt = HALTED;
      HALTED:                      state_nxt = HALTED;
      default:                     state_nxt = RUN;
    endcase
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state     <= RUN;
      overflow  <= 1'b0;
      res_count <= '0;
    end else begin
      state <= state_nxt;
      if (push_req && full && !pop) overflow <= 1'b1;
      if (pop) res_count <= res_count + CNT_ONE;
    end
  end

  haski_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (system1000),
    .rst       (system1000_rst),
    .push      (push),
    .push_data (in_q[DATA_W:RES_LSB]),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (res_data)
  );

endmodule

// File: tb/tb_haski_result_receiver.sv
// Self-checking bench for haski_result_receiver: a cycle table for the basic
// latency case plus scoreboarded sequences for FIFO, halt and reset corners.
module tb_haski_result_receiver;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W+1:0] core_i = '0;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              halted;
  logic              overflow;
  logic [CNT_W-1:0]  res_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [DATA_W+1:0] core;
    logic              ready;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  exp_count;
    logic              exp_halted;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  haski_result_receiver #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .core_i         (core_i),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .halted         (halted),
    .overflow       (overflow),
    .res_count      (res_count)
  );

  function automatic logic [DATA_W+1:0] mk(input logic v, input logic [DATA_W-1:0] d,
                                           input logic h);
    return {v, d, h};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs are final at this point; a transfer seen now happens on the next edge.
  task automatic step();
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_transfer: actual data=%0h required no transfer", res_data);
      end else begin
        check("sb_data", {32'h0, res_data}, {32'h0, exp_q.pop_front()});
      end
      n_xfer++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && res_valid; i++) step();
    check("drain_timeout", {63'h0, res_valid}, 64'h0);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    core_i    = '0;
    res_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    n_xfer = 0;
    check("rst_valid",    {63'h0, res_valid}, 64'h0);
    check("rst_data",     {32'h0, res_data},  64'h0);
    check("rst_count",    {48'h0, res_count}, 64'h0);
    check("rst_halted",   {63'h0, halted},    64'h0);
    check("rst_overflow", {63'h0, overflow},  64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Row i: inputs before edge i, expectations after edge i.
    vecs[0] = '{mk(1'b1, 32'hDEAD_BEEF, 1'b0), 1'b1, 1'b0, 32'h0,         16'd0, 1'b0, 1'b0};
    vecs[1] = '{mk(1'b0, 32'h0,         1'b0), 1'b1, 1'b1, 32'hDEAD_BEEF, 16'd0, 1'b0, 1'b0};
    vecs[2] = '{mk(1'b0, 32'h0,         1'b0), 1'b1, 1'b0, 32'h0,         16'd1, 1'b0, 1'b0};
    vecs[3] = '{mk(1'b0, 32'h0,         1'b0), 1'b1, 1'b0, 32'h0,         16'd1, 1'b0, 1'b0};

    apply_reset();

    // Single result latency table.
    for (int r = 0; r < 4; r++) begin
      core_i    = vecs[r].core;
      res_ready = vecs[r].ready;
      if (vecs[r].core[DATA_W+1]) exp_q.push_back(vecs[r].core[DATA_W:1]);
      step();
      check($sformatf("tbl%0d_valid", r),  {63'h0, res_valid}, {63'h0, vecs[r].exp_valid});
      check($sformatf("tbl%0d_data", r),   {32'h0, res_data},  {32'h0, vecs[r].exp_data});
      check($sformatf("tbl%0d_count", r),  {48'h0, res_count}, {48'h0, vecs[r].exp_count});
      check($sformatf("tbl%0d_halted", r), {63'h0, halted},    {63'h0, vecs[r].exp_halted});
      check($sformatf("tbl%0d_ovf", r),    {63'h0, overflow},  {63'h0, vecs[r].exp_ovf});
    end

    // Ten results into an eight-deep FIFO with downstream stalled.
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      core_i = mk(1'b1, 32'(i), 1'b0);
      if (i <= DEPTH) exp_q.push_back(32'(i));
      step();
    end
    core_i = '0;
    step();
    step();
    check("ovf_set",    {63'h0, overflow},  64'h1);
    check("ovf_head",   {32'h0, res_data},  64'h1);
    check("ovf_count0", {48'h0, res_count}, 64'h0);
    res_ready = 1'b1;
    drain(20);
    check("ovf_xfers",   64'(n_xfer),       64'd8);
    check("ovf_sb_left", 64'(exp_q.size()), 64'd0);
    check("ovf_count8",  {48'h0, res_count}, 64'd8);
    check("ovf_sticky",  {63'h0, overflow},  64'h1);

    // Full FIFO with a push and a pop every cycle.
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      core_i = mk(1'b1, 32'(i), 1'b0);
      exp_q.push_back(32'(i));
      step();
    end
    res_ready = 1'b1;
    for (int i = 10; i <= 29; i++) begin
      core_i = mk(1'b1, 32'(i), 1'b0);
      exp_q.push_back(32'(i));
      step();
      check("full_pp_ovf", {63'h0, overflow}, 64'h0);
    end
    core_i = '0;
    drain(20);
    check("full_pp_xfers", 64'(n_xfer),        64'd29);
    check("full_pp_count", {48'h0, res_count}, 64'd29);
    check("full_pp_left",  64'(exp_q.size()),  64'd0);

    // Halt together with a result, three already queued.
    apply_reset();
    core_i = mk(1'b1, 32'hA, 1'b0); exp_q.push_back(32'hA); step();
    core_i = mk(1'b1, 32'hB, 1'b0); exp_q.push_back(32'hB); step();
    core_i = mk(1'b1, 32'hC, 1'b0); exp_q.push_back(32'hC); step();
    core_i = mk(1'b1, 32'h5, 1'b1); exp_q.push_back(32'h5); step();
    core_i = '0;                     step();
    core_i = mk(1'b1, 32'h7, 1'b0); step();
    core_i = '0;
    step();
    step();
    check("halt_pre_halted", {63'h0, halted},   64'h0);
    check("halt_pre_ovf",    {63'h0, overflow}, 64'h0);
    res_ready = 1'b1;
    for (int i = 0; i < 20 && res_valid; i++) begin
      check("halt_drain_halted", {63'h0, halted}, 64'h0);
      step();
    end
    check("halt_empty_valid",  {63'h0, res_valid}, 64'h0);
    check("halt_empty_halted", {63'h0, halted},    64'h0);
    step();
    check("halt_rise",   {63'h0, halted},    64'h1);
    check("halt_xfers",  64'(n_xfer),        64'd4);
    check("halt_count",  {48'h0, res_count}, 64'd4);
    check("halt_ovf",    {63'h0, overflow},  64'h0);
    core_i = mk(1'b1, 32'h9, 1'b1);
    step();
    core_i = '0;
    step();
    step();
    check("halt_ignore_valid",  {63'h0, res_valid}, 64'h0);
    check("halt_ignore_halted", {63'h0, halted},    64'h1);

    // Stalled head stays stable.
    apply_reset();
    core_i = mk(1'b1, 32'h1234, 1'b0);
    exp_q.push_back(32'h1234);
    step();
    core_i = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {63'h0, res_valid}, 64'h1);
      check("stall_data",  {32'h0, res_data},  64'h1234);
      check("stall_count", {48'h0, res_count}, 64'h0);
      step();
    end
    res_ready = 1'b1;
    drain(10);
    check("stall_count1", {48'h0, res_count}, 64'd1);

    // Asynchronous reset with the FIFO half full.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      core_i = mk(1'b1, 32'h100 + 32'(i), 1'b0);
      exp_q.push_back(32'h100 + 32'(i));
      step();
    end
    core_i = '0;
    step();
    step();
    res_ready = 1'b1;
    step();
    step();
    check("mid_count2", {48'h0, res_count}, 64'd2);
    check("mid_valid1", {63'h0, res_valid}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", {63'h0, res_valid}, 64'h0);
    check("async_data",  {32'h0, res_data},  64'h0);
    check("async_count", {48'h0, res_count}, 64'h0);
    check("async_halted", {63'h0, halted},   64'h0);
    check("async_ovf",   {63'h0, overflow},  64'h0);
    exp_q.delete();
    @(negedge clk);
    rst    = 1'b0;
    n_xfer = 0;
    core_i = mk(1'b1, 32'h1, 1'b0);
    exp_q.push_back(32'h1);
    step();
    core_i = '0;
    step();
    check("post_rst_valid", {63'h0, res_valid}, 64'h1);
    drain(10);
    check("post_rst_xfers", 64'(n_xfer),        64'd1);
    check("post_rst_count", {48'h0, res_count}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
